// File: rtl/data_mover_burst_pkg.sv
// Shared definitions for the burst RAM->FIFO mover: FSM encoding, mode
// constants and the small sizing helpers used by the top and tick divider.
package data_mover_burst_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_PUSH  = 2'd3
    } state_t;

    localparam logic MODE_WRAP    = 1'b0;
    localparam logic MODE_ONESHOT = 1'b1;

    // Clock cycles between update ticks.
    function automatic int calc_tick_div(input int clk_freq, input int update_period);
        return clk_freq / update_period;
    endfunction

    // Bits needed to hold any value 0..max_value (never less than one bit).
    function automatic int cnt_width(input int max_value);
        return (max_value < 2) ? 1 : $clog2(max_value + 1);
    endfunction

endpackage

// File: rtl/data_mover_burst_tick_gen.sv
// Tick divider: counts enabled cycles 0..DIV-1 and flags the last one.
// The count freezes while enable is low, so a pause stretches the period.
module data_mover_burst_tick_gen
    import data_mover_burst_pkg::*;
#(
    parameter int DIV = 10
) (
    input  logic clock,
    input  logic rstn,
    input  logic enable,
    output logic tick
);

    localparam int CW = cnt_width(DIV - 1);

    logic [CW-1:0] tick_cnt_reg;

    // Gate with enable so a frozen count at DIV-1 does not tick every cycle.
    assign tick = enable && (tick_cnt_reg == CW'(DIV - 1));

    // Free-running divider that only advances while enabled.
    always_ff @(posedge clock) begin
        if (!rstn) begin
            tick_cnt_reg <= '0;
        end else if (enable) begin
            if (tick) begin
                tick_cnt_reg <= '0;
            end else begin
                tick_cnt_reg <= tick_cnt_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/data_mover_burst.sv
// Burst mover: on each tick copies BURST_LEN words from a synchronous RAM
// window [start_addr..end_addr] into a FIFO, stalling on fifo_full.
// ram_addr always mirrors the read pointer, so the address is already on
// the RAM port during ISSUE and WAIT only needs RAM_LATENCY cycles.
module data_mover_burst
    import data_mover_burst_pkg::*;
#(
    parameter int DATA_W        = 16,
    parameter int ADDR_W        = 5,
    parameter int CLK_FREQ      = 500,
    parameter int UPDATE_PERIOD = 50,
    parameter int BURST_LEN     = 4,
    parameter int RAM_LATENCY   = 1
) (
    input  logic              clock,
    input  logic              rstn,
    input  logic              enable,
    input  logic              mode,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] end_addr,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_data_in,
    output logic [DATA_W-1:0] fifo_data_out,
    output logic              fifo_wrreq,
    input  logic              fifo_full,
    output logic              busy,
    output logic              done,
    output logic              overrun
);

    localparam int TICK_DIV = calc_tick_div(CLK_FREQ, UPDATE_PERIOD);
    localparam int BEAT_W   = cnt_width(BURST_LEN);
    localparam int LAT_W    = cnt_width(RAM_LATENCY);

    state_t            state_reg;
    logic [ADDR_W-1:0] ptr_reg;
    logic [BEAT_W-1:0] beat_cnt_reg;
    logic [BEAT_W-1:0] beat_next;
    logic [LAT_W-1:0]  lat_cnt_reg;
    logic [DATA_W-1:0] hold_reg;
    logic              pending_reg;
    logic              done_reg;
    logic              overrun_reg;
    logic              tick;
    logic              consume;
    logic              at_end;

    data_mover_burst_tick_gen #(
        .DIV (TICK_DIV)
    ) u_tick_gen (
        .clock  (clock),
        .rstn   (rstn),
        .enable (enable),
        .tick   (tick)
    );

    // A queued burst is taken only from IDLE, while running and not finished.
    assign consume   = (state_reg == ST_IDLE) && pending_reg && enable && !done_reg;
    assign at_end    = (ptr_reg == end_addr);
    assign beat_next = beat_cnt_reg + 1'b1;

    assign ram_addr      = ptr_reg;
    assign fifo_data_out = hold_reg;
    // Write strobe follows fifo_full directly so it can never hit a full FIFO.
    assign fifo_wrreq    = (state_reg == ST_PUSH) && !fifo_full;
    assign busy          = (state_reg != ST_IDLE);
    assign done          = done_reg;
    assign overrun       = overrun_reg;

    // One-deep tick queue; a tick landing on a still-queued burst is dropped
    // and flagged. A tick coinciding with the queue being taken is kept.
    always_ff @(posedge clock) begin
        if (!rstn) begin
            pending_reg <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            overrun_reg <= tick && pending_reg && !consume;
            pending_reg <= tick || (pending_reg && !consume);
        end
    end

    // Burst sequencer: fetch one word, wait for RAM data, push it, repeat.
    always_ff @(posedge clock) begin
        if (!rstn) begin
            state_reg    <= ST_IDLE;
            ptr_reg      <= start_addr;
            beat_cnt_reg <= '0;
            lat_cnt_reg  <= '0;
            hold_reg     <= '0;
            done_reg     <= 1'b0;
        end else begin
            unique case (state_reg)
                ST_IDLE: begin
                    if (consume) begin
                        state_reg    <= ST_ISSUE;
                        beat_cnt_reg <= '0;
                    end
                end
                ST_ISSUE: begin
                    lat_cnt_reg <= LAT_W'(RAM_LATENCY);
                    state_reg   <= ST_WAIT;
                end
                ST_WAIT: begin
                    lat_cnt_reg <= lat_cnt_reg - 1'b1;
                    if (lat_cnt_reg == LAT_W'(1)) begin
                        hold_reg  <= ram_data_in;
                        state_reg <= ST_PUSH;
                    end
                end
                ST_PUSH: begin
                    if (!fifo_full) begin
                        beat_cnt_reg <= beat_next;
                        if (at_end) begin
                            ptr_reg <= start_addr;
                        end else begin
                            ptr_reg <= ptr_reg + 1'b1;
                        end
                        if (at_end && (mode == MODE_ONESHOT)) begin
                            done_reg  <= 1'b1;
                            state_reg <= ST_IDLE;
                        end else if ((beat_next == BEAT_W'(BURST_LEN)) || !enable) begin
                            state_reg <= ST_IDLE;
                        end else begin
                            state_reg <= ST_ISSUE;
                        end
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mover_burst.sv
// Directed bench for data_mover_burst with a RAM model holding RAM[i]=i.
`timescale 1ns/1ps
module tb_data_mover_burst;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 5;

    logic              clock = 1'b0;
    logic              rstn;
    logic              enable;
    logic              mode;
    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W-1:0] end_addr;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_data_in = '0;
    logic [DATA_W-1:0] fifo_data_out;
    logic              fifo_wrreq;
    logic              fifo_full;
    logic              busy;
    logic              done;
    logic              overrun;

    logic tg_rstn;
    logic tg_enable;
    logic tg_tick;

    int n_vectors     = 0;
    int n_miscompares = 0;
    int cyc           = 0;
    int ovr_cnt       = 0;
    int full_viol     = 0;
    int wr_q[$];
    int wr_cyc_q[$];

    always #5 clock = ~clock;

    data_mover_burst #(
        .DATA_W        (DATA_W),
        .ADDR_W        (ADDR_W),
        .CLK_FREQ      (500),
        .UPDATE_PERIOD (50),
        .BURST_LEN     (4),
        .RAM_LATENCY   (1)
    ) dut (
        .clock         (clock),
        .rstn          (rstn),
        .enable        (enable),
        .mode          (mode),
        .start_addr    (start_addr),
        .end_addr      (end_addr),
        .ram_addr      (ram_addr),
        .ram_data_in   (ram_data_in),
        .fifo_data_out (fifo_data_out),
        .fifo_wrreq    (fifo_wrreq),
        .fifo_full     (fifo_full),
        .busy          (busy),
        .done          (done),
        .overrun       (overrun)
    );

    data_mover_burst_tick_gen #(
        .DIV (10)
    ) u_tick_ref (
        .clock  (clock),
        .rstn   (tg_rstn),
        .enable (tg_enable),
        .tick   (tg_tick)
    );

    // RAM model: RAM[i] = i, one-cycle registered read; also a cycle counter.
    always @(posedge clock) begin
        ram_data_in <= DATA_W'(ram_addr);
        cyc         <= cyc + 1;
    end

    // FIFO-side monitor: log every written word and its cycle.
    always @(negedge clock) begin
        if (fifo_wrreq === 1'b1) begin
            wr_q.push_back(int'(fifo_data_out));
            wr_cyc_q.push_back(cyc);
            $display("write  cyc=%0d data=%0d", cyc, fifo_data_out);
        end
        if (overrun === 1'b1) ovr_cnt++;
        if (fifo_wrreq === 1'b1 && fifo_full === 1'b1) full_viol++;
    end

    task automatic check_value(input string tag, input int obs, input int exp);
        n_vectors++;
        if (obs !== exp) begin
            n_miscompares++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    task automatic do_reset(input int s, input int e, input logic m);
        @(posedge clock); #2;
        rstn       = 1'b0;
        enable     = 1'b0;
        start_addr = ADDR_W'(s);
        end_addr   = ADDR_W'(e);
        mode       = m;
        @(posedge clock);
        @(posedge clock); #2;
        wr_q.delete();
        wr_cyc_q.delete();
        rstn   = 1'b1;
        enable = 1'b1;
    endtask

    task automatic wait_writes(input int n, input int budget, input string tag);
        int k = 0;
        while (wr_q.size() < n && k < budget) begin
            @(posedge clock);
            k++;
        end
        #2;
        check_value(tag, (wr_q.size() >= n) ? n : wr_q.size(), n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int o0;
        int exp7[6] = '{30, 31, 0, 1, 30, 31};

        rstn = 1'b0; enable = 1'b0; mode = 1'b0;
        start_addr = 5'd5; end_addr = 5'd31; fifo_full = 1'b0;
        tg_rstn = 1'b0; tg_enable = 1'b0;

        // Reset values
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_value("rst_ram_addr", int'(ram_addr), 5);
        check_value("rst_wrreq", int'(fifo_wrreq), 0);
        check_value("rst_data", int'(fifo_data_out), 0);
        check_value("rst_busy", int'(busy), 0);
        check_value("rst_done", int'(done), 0);
        check_value("rst_overrun", int'(overrun), 0);

        // Tick divider: 10 enabled cycles per tick, frozen while disabled
        tg_rstn = 1'b1; tg_enable = 1'b1;
        n = 0;
        while (tg_tick !== 1'b1 && n < 50) begin
            @(negedge clock);
            n++;
        end
        check_value("tick_first", n, 9);
        tg_enable = 1'b0; #1;
        check_value("tick_off", int'(tg_tick), 0);
        repeat (3) @(negedge clock);
        tg_enable = 1'b1; #1;
        check_value("tick_resume", int'(tg_tick), 1);
        tg_enable = 1'b0;

        // 1: full window wrap, FIFO drained
        do_reset(0, 31, 1'b0);
        wait_writes(34, 600, "t1_count");
        for (int i = 0; i < 34; i++)
            check_value($sformatf("t1_word%0d", i), wr_q[i], i % 32);
        check_value("t1_gap01", wr_cyc_q[1] - wr_cyc_q[0], 3);
        check_value("t1_gap23", wr_cyc_q[3] - wr_cyc_q[2], 3);
        check_value("t1_gap34", wr_cyc_q[4] - wr_cyc_q[3], 4);

        // 2: one-shot pass over 28..31
        do_reset(28, 31, 1'b1);
        wait_writes(4, 100, "t2_count");
        for (int i = 0; i < 4; i++)
            check_value($sformatf("t2_word%0d", i), wr_q[i], 28 + i);
        repeat (50) @(posedge clock); #2;
        check_value("t2_no_more", wr_q.size(), 4);
        check_value("t2_done", int'(done), 1);
        check_value("t2_idle", int'(busy), 0);

        // 3: backpressure for ~20 cycles during PUSH
        do_reset(0, 31, 1'b0);
        wait_writes(1, 100, "t3_first");
        fifo_full = 1'b1;
        repeat (10) @(negedge clock);
        check_value("t3_wrreq_held", int'(fifo_wrreq), 0);
        check_value("t3_busy", int'(busy), 1);
        check_value("t3_data_held", int'(fifo_data_out), 1);
        check_value("t3_count_full", wr_q.size(), 1);
        repeat (10) @(posedge clock); #2;
        fifo_full = 1'b0;
        wait_writes(8, 200, "t3_count");
        for (int i = 0; i < 8; i++)
            check_value($sformatf("t3_word%0d", i), wr_q[i], i);

        // 4: FIFO full from the start for 45 cycles -> two dropped ticks
        fifo_full = 1'b1;
        do_reset(0, 31, 1'b0);
        o0 = ovr_cnt;
        repeat (45) @(posedge clock); #2;
        check_value("t4_overruns", ovr_cnt - o0, 2);
        check_value("t4_no_write", wr_q.size(), 0);
        fifo_full = 1'b0;
        wait_writes(8, 200, "t4_count");
        for (int i = 0; i < 8; i++)
            check_value($sformatf("t4_word%0d", i), wr_q[i], i);

        // 5: enable drops during WAIT
        do_reset(0, 31, 1'b0);
        wait_writes(1, 100, "t5_first");
        @(posedge clock); #2;
        enable = 1'b0;
        @(negedge clock);
        check_value("t5_busy_wait", int'(busy), 1);
        repeat (20) @(posedge clock); #2;
        check_value("t5_count_off", wr_q.size(), 2);
        check_value("t5_idle", int'(busy), 0);
        check_value("t5_word1", wr_q[1], 1);
        enable = 1'b1;
        wait_writes(3, 100, "t5_resume");
        check_value("t5_word2", wr_q[2], 2);

        // 6: reset mid-burst
        do_reset(3, 31, 1'b0);
        wait_writes(2, 100, "t6_first");
        rstn = 1'b0;
        @(posedge clock);
        @(negedge clock);
        check_value("t6_wrreq", int'(fifo_wrreq), 0);
        check_value("t6_busy", int'(busy), 0);
        check_value("t6_data", int'(fifo_data_out), 0);
        check_value("t6_ram_addr", int'(ram_addr), 3);
        check_value("t6_overrun", int'(overrun), 0);
        check_value("t6_no_write", wr_q.size(), 2);
        rstn = 1'b1;
        wr_q.delete();
        wr_cyc_q.delete();
        wait_writes(2, 100, "t6_restart");
        check_value("t6_word0", wr_q[0], 3);
        check_value("t6_word1", wr_q[1], 4);

        // 7: window wrapping through 31 -> 0
        do_reset(30, 1, 1'b0);
        wait_writes(6, 200, "t7_count");
        for (int i = 0; i < 6; i++)
            check_value($sformatf("t7_word%0d", i), wr_q[i], exp7[i]);

        check_value("no_wrreq_while_full", full_viol, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
